// File: rtl/nested_sqrt_pipe_using_fifos.sv
// Nested integer square root pipeline: res = isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))).
// Side operands wait in FIFOs; a credit counter bounds in-flight work to the output FIFO depth.

module nested_sqrt_pipe_using_fifos_isqrt #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [WIDTH-1:0]   x,
    output logic               y_vld,
    output logic [WIDTH/2-1:0] y
);
    localparam int H   = WIDTH / 2;
    localparam int RN  = H + 1;
    localparam int RSW = RN + 2;

    // One result bit per stage; the remaining operand bits shrink by two each stage.
    for (genvar k = 0; k < H; k++) begin : g_stg
        localparam int XW = WIDTH - 2 * k;
        logic [XW-1:0]  x_in;
        logic [RN-1:0]  r_in;
        logic [H-1:0]   q_in;
        logic           v_in;
        logic [RSW-1:0] r_sh;
        logic [RSW-1:0] trial;
        logic           ge;
        logic [H-1:0]   root_q;
        logic           vld_q;

        if (k == 0) begin : g_first
            assign x_in = x;
            assign r_in = '0;
            assign q_in = '0;
            assign v_in = x_vld;
        end else begin : g_next
            assign x_in = g_stg[k-1].g_fwd.xs_q;
            assign r_in = g_stg[k-1].g_fwd.rem_q;
            assign q_in = g_stg[k-1].root_q;
            assign v_in = g_stg[k-1].vld_q;
        end

        assign r_sh  = {r_in, x_in[XW-1 -: 2]};
        assign trial = RSW'({q_in, 2'b01});
        assign ge    = (r_sh >= trial);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= v_in;
            end
            root_q <= ge ? ((q_in << 1) | H'(1)) : (q_in << 1);
        end

        if (k < H - 1) begin : g_fwd
            logic [XW-3:0] xs_q;
            logic [RN-1:0] rem_q;

            always_ff @(posedge clk) begin
                xs_q  <= x_in[XW-3:0];
                rem_q <= ge ? RN'(r_sh - trial) : RN'(r_sh);
            end
        end
    end

    assign y     = g_stg[H-1].root_q;
    assign y_vld = g_stg[H-1].vld_q;
endmodule

module nested_sqrt_pipe_using_fifos #(
    parameter int N_STAGES      = 3,
    parameter int WIDTH         = 32,
    parameter int ISQRT_LATENCY = 16,
    parameter int OUT_DEPTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arg_vld,
    output logic                      arg_rdy,
    input  logic [N_STAGES*WIDTH-1:0] args,
    output logic                      res_vld,
    input  logic                      res_rdy,
    output logic [WIDTH/2-1:0]        res,
    output logic                      err
);
    localparam int H   = WIDTH / 2;
    localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    logic                accept;
    logic                pop;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    stg_x [N_STAGES];
    logic [H-1:0]        stg_y [N_STAGES];
    logic [N_STAGES-1:0] stg_xv;
    logic [N_STAGES-1:0] stg_yv;
    logic [N_STAGES-1:0] side_err;

    assign arg_rdy = (cnt_q < CW'(OUT_DEPTH));
    assign accept  = arg_vld & arg_rdy;
    assign pop     = res_vld & res_rdy;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_sqrt
        nested_sqrt_pipe_using_fifos_isqrt #(
            .WIDTH (WIDTH)
        ) u_isqrt (
            .clk   (clk),
            .rst   (rst),
            .x_vld (stg_xv[i]),
            .x     (stg_x[i]),
            .y_vld (stg_yv[i]),
            .y     (stg_y[i])
        );
    end

    // The innermost operand goes straight into the deepest isqrt.
    assign stg_x[N_STAGES-1]    = args[(N_STAGES-1)*WIDTH +: WIDTH];
    assign stg_xv[N_STAGES-1]   = accept;
    assign side_err[N_STAGES-1] = 1'b0;

    for (genvar i = 0; i < N_STAGES - 1; i++) begin : g_side
        localparam int SAW = $clog2((N_STAGES - 1 - i) * (ISQRT_LATENCY + 1) + 1);
        localparam int SD  = 2 ** SAW;
        localparam int SCW = SAW + 1;

        logic [WIDTH-1:0] mem [SD];
        logic [SAW-1:0]   wp_q, rp_q;
        logic [SCW-1:0]   fcnt_q;
        logic [WIDTH-1:0] sum_q;
        logic             sum_vld_q;
        logic             push, pop_s, full, empty, push_ok, pop_ok;

        assign push    = accept;
        assign pop_s   = stg_yv[i+1];
        assign full    = (fcnt_q == SCW'(SD));
        assign empty   = (fcnt_q == '0);
        assign push_ok = push & ~full;
        assign pop_ok  = pop_s & ~empty;
        assign side_err[i] = (push & full) | (pop_s & empty);

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wp_q] <= args[i*WIDTH +: WIDTH];
            end
            sum_q <= mem[rp_q] + WIDTH'(stg_y[i+1]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wp_q      <= '0;
                rp_q      <= '0;
                fcnt_q    <= '0;
                sum_vld_q <= 1'b0;
            end else begin
                if (push_ok) wp_q <= wp_q + SAW'(1);
                if (pop_ok)  rp_q <= rp_q + SAW'(1);
                fcnt_q    <= fcnt_q + SCW'(push_ok) - SCW'(pop_ok);
                sum_vld_q <= pop_s;
            end
        end

        assign stg_x[i]  = sum_q;
        assign stg_xv[i] = sum_vld_q;
    end

    // Output FIFO, first-word-fall-through; credits guarantee it never overflows.
    logic [H-1:0]   omem [2**OAW];
    logic [OAW-1:0] owp_q, orp_q;
    logic [CW-1:0]  ocnt_q;
    logic           opush, ofull, opush_ok;
    logic           err_q;

    assign opush    = stg_yv[0];
    assign ofull    = (ocnt_q == CW'(OUT_DEPTH));
    assign opush_ok = opush & ~ofull;
    assign res_vld  = (ocnt_q != '0);
    assign res      = res_vld ? omem[orp_q] : '0;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (opush_ok) begin
            omem[owp_q] <= stg_y[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owp_q  <= '0;
            orp_q  <= '0;
            ocnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (opush_ok) owp_q <= owp_q + OAW'(1);
            if (pop)      orp_q <= orp_q + OAW'(1);
            ocnt_q <= ocnt_q + CW'(opush_ok) - CW'(pop);
            if ((|side_err) | (opush & ofull)) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nested_sqrt_pipe_using_fifos.sv
// Directed bench for the nested isqrt pipeline: latency, wrap, throughput, backpressure, reset.
`timescale 1ns/1ps

module tb_nested_sqrt_pipe_using_fifos;
    logic        clk = 1'b0;
    logic        rst;
    logic        arg_vld, arg_rdy, res_vld, res_rdy, err;
    logic [95:0] args;
    logic [15:0] res;

    logic        d1_arg_vld, d1_arg_rdy, d1_res_vld, d1_res_rdy, d1_err;
    logic [15:0] d1_args;
    logic [7:0]  d1_res;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int stall_cnt = 0;
    logic [15:0] exp_q[$];
    int          out_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nested_sqrt_pipe_using_fifos dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .err(err)
    );

    nested_sqrt_pipe_using_fifos #(
        .N_STAGES(1), .WIDTH(16), .ISQRT_LATENCY(8), .OUT_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst), .arg_vld(d1_arg_vld), .arg_rdy(d1_arg_rdy), .args(d1_args),
        .res_vld(d1_res_vld), .res_rdy(d1_res_rdy), .res(d1_res), .err(d1_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] c;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            c = r | (16'd1 << b);
            if ({32'd0, c} * {32'd0, c} <= {32'd0, v}) r = c;
        end
        return r;
    endfunction

    function automatic logic [15:0] nest(input logic [95:0] a);
        logic [15:0] y;
        logic [31:0] s;
        y = isqrt_ref(a[95:64]);
        s = a[63:32] + {16'd0, y};
        y = isqrt_ref(s);
        s = a[31:0] + {16'd0, y};
        return isqrt_ref(s);
    endfunction

    function automatic logic [95:0] bp_vec(input int n);
        return {32'(n * 7), 32'(n * n), 32'(n + 50)};
    endfunction

    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
            else chk("res", res, exp_q.pop_front());
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic send(input logic [95:0] a, input logic [15:0] e);
        int k;
        arg_vld = 1'b1;
        args = a;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (arg_rdy) break;
        end
        if (k == 500) chk("send_timeout", 0, 1);
        else begin
            if (k > 0) stall_cnt++;
            exp_q.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clk); #1;
        arg_vld = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, n_acc, k;
        logic [95:0] a;
        rst = 1'b1; arg_vld = 1'b0; args = '0; res_rdy = 1'b1;
        d1_arg_vld = 1'b0; d1_args = '0; d1_res_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_res", res, 0);
        chk("rst_err", err, 0);
        chk("rst_arg_rdy", arg_rdy, 1);
        chk("rst_d1_arg_rdy", d1_arg_rdy, 1);
        @(posedge clk); #1;

        // single set: 16 -> 4, 12+4 -> 4, 21+4 -> 5
        send({32'd16, 32'd12, 32'd21}, 16'd5);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (res_vld) break;
        end
        chk("lat", cyc - acc_cyc, 51);
        chk("err_single", err, 0);
        drain();

        // wrap: 65535; 0xFFFFFFFF+65535 -> 65534 -> 255; +255 -> 254 -> 15
        send({3{32'hFFFF_FFFF}}, 16'd15);
        drain();

        base = out_cyc_q.size();
        stall_cnt = 0;
        for (int j = 0; j < 200; j++) begin
            a = {$urandom, $urandom, $urandom};
            if (j % 4 == 0) a[31:0] = 32'(j);
            send(a, nest(a));
        end
        drain();
        chk("tput_stall", stall_cnt, 0);
        chk("tput_count", out_cyc_q.size() - base, 200);
        if (out_cyc_q.size() >= base + 200)
            chk("tput_span", out_cyc_q[base+199] - out_cyc_q[base], 199);

        // backpressure
        base = out_cyc_q.size();
        res_rdy = 1'b0;
        n_acc = 0;
        arg_vld = 1'b1;
        args = bp_vec(0);
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (arg_rdy) begin
                exp_q.push_back(nest(args));
                n_acc++;
            end
            @(posedge clk); #1;
            args = bp_vec(n_acc);
        end
        arg_vld = 1'b0;
        @(negedge clk);
        chk("bp_accepts", n_acc, 64);
        chk("bp_rdy_low", arg_rdy, 0);
        chk("bp_vld", res_vld, 1);
        chk("bp_head0", res, nest(bp_vec(0)));
        @(negedge clk);
        chk("bp_head1", res, nest(bp_vec(0)));
        @(posedge clk); #1;
        res_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rdy_at_pop", arg_rdy, 0);
        @(negedge clk);
        chk("bp_rdy_back", arg_rdy, 1);
        drain();
        chk("bp_drained", out_cyc_q.size() - base, 64);

        // reset mid-flight
        for (int j = 0; j < 10; j++) send(bp_vec(j + 3), nest(bp_vec(j + 3)));
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        base = out_cyc_q.size();
        n_acc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_vld) n_acc++;
        end
        chk("rst_quiet", n_acc, 0);
        chk("rst_cnt", dut.cnt_q, 0);
        chk("rst_rdy", arg_rdy, 1);
        chk("rst_err_mid", err, 0);
        @(posedge clk); #1;
        // 100 -> 10, 0+10 -> 3, 100+3 -> 10
        send({32'd100, 32'd0, 32'd100}, 16'd10);
        drain();
        chk("rst_fresh", out_cyc_q.size() - base, 1);

        // single-stage instance: isqrt(1000) = 31
        d1_args = 16'd1000;
        d1_arg_vld = 1'b1;
        @(negedge clk);
        chk("d1_acc", d1_arg_rdy, 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        d1_arg_vld = 1'b0;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (d1_res_vld) break;
        end
        chk("d1_lat", cyc - acc_cyc, 9);
        chk("d1_res", d1_res, 31);

        chk("err_final", err, 0);
        chk("d1_err_final", d1_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
